// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Stalls the pipeline while busy and writes {remainder, quotient} to HI/LO once.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic        stall_o,
  output logic        ready_o,
  output logic [63:0] result_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*W-1:0]    work_q, work_d;
  logic [W-1:0]      dvs_q, dvs_d;
  logic [W-1:0]      dvd_q, dvd_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [2*W-1:0]    result_q, result_d;

  logic [W-1:0]      mag1, mag2;
  logic [2*W:0]      shifted;
  logic              ge;
  logic [W-1:0]      diff;
  logic [2*W-1:0]    step;
  logic [W-1:0]      quo_fin, rem_fin;

  // Operand magnitudes; abs(0x80000000) wraps to itself and is used as unsigned
  assign mag1 = (signed_i && opdata1_i[W-1]) ? (~opdata1_i + W'(1)) : opdata1_i;
  assign mag2 = (signed_i && opdata2_i[W-1]) ? (~opdata2_i + W'(1)) : opdata2_i;

  // One restoring step: shift, trial-subtract, keep difference when non-negative
  assign shifted = {work_q, 1'b0};
  assign ge      = shifted[2*W:W] >= {1'b0, dvs_q};
  assign diff    = W'(shifted[2*W:W] - {1'b0, dvs_q});
  assign step    = ge ? {diff, shifted[W-1:1], 1'b1} : shifted[2*W-1:0];

  assign quo_fin = neg_quo_q ? (~step[W-1:0] + W'(1))   : step[W-1:0];
  assign rem_fin = neg_rem_q ? (~step[2*W-1:W] + W'(1)) : step[2*W-1:W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      dvs_q     <= dvs_d;
      dvd_q     <= dvd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = ready_q;
    we_d      = 1'b0;
    result_d  = result_q;
    stall_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b0;
        if (start_i && !annul_i) begin
          stall_o   = 1'b1;
          neg_quo_d = signed_i && (opdata1_i[W-1] ^ opdata2_i[W-1]);
          neg_rem_d = signed_i && opdata1_i[W-1];
          dvd_d     = opdata1_i;
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            work_d  = {W'(0), mag1};
            dvs_d   = mag2;
            cnt_d   = '0;
            state_d = S_ON;
          end
        end
      end

      S_BYZERO: begin
        stall_o = 1'b1;
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          ready_d  = 1'b1;
          we_d     = 1'b1;
          result_d = {dvd_q, {W{1'b1}}};
        end
      end

      S_ON: begin
        stall_o = 1'b1;
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          work_d = step;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            state_d  = S_END;
            ready_d  = 1'b1;
            we_d     = 1'b1;
            result_d = {rem_fin, quo_fin};
          end
        end
      end

      S_END: begin
        // Result stays presented until the requester drops start_i
        if (!start_i) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ready_o   = ready_q;
  assign hilo_we_o = we_q;
  assign result_o  = result_q;
  assign hi_o      = result_q[2*W-1:W];
  assign lo_o      = result_q[W-1:0];

endmodule
